weight_biu: RTL
===============

Name: weight_biu

Overview:
- Weight bus-interface unit sitting directly upstream of the accelerator's ICB arbiter.
- On a start pulse it fetches a contiguous block of 32-bit weight words from system memory through the arbiter's weight request/response channel.
- It writes each returned word into the on-chip weight buffer and reports done.
- One read command outstanding at a time; holds its arbitration request for the whole transfer.

Parameters:
- LEN_W, 12, width of the word-count input (max transfer 2^LEN_W-1 words).
- BUF_AW, 10, weight buffer write-address width.
- TIMEOUT_CYC, 1024, response watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, active-low
- start  in  1  one-cycle start pulse; ignored while busy
- base_addr  in  32  byte address of first weight word, word-aligned
- len  in  LEN_W  number of 32-bit words to fetch
- buf_base  in  BUF_AW  first weight buffer write address
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag, cleared by next accepted start
- weight_biu2arb_req  out  1  arbitration request
- weight_biu2arb_addr  out  32  read address
- weight_biu2arb_vld  out  1  command valid
- weight_biu2arb_rdy  in  1  grant/command ready
- arb2weight_biu_data  in  32  response data
- arb2weight_biu_vld  in  1  response valid
- arb2weight_biu_rdy  out  1  response ready
- wbuf_wr_en  out  1  buffer write strobe
- wbuf_wr_addr  out  BUF_AW  buffer write address
- wbuf_wr_data  out  32  buffer write data

Behaviour:
- Single clock clk. Asynchronous active-low reset rst_n clears all state; every output resets to 0, FSM to IDLE. Reset mid-transfer aborts silently: no done, and the buffer keeps the partial data.
- All outputs are registered except arb2weight_biu_rdy, which is decoded from state.
- FSM states: IDLE, CMD, RSP, FIN.
- IDLE:
  - On start with len!=0: latch base_addr, len and buf_base; clear word index idx and err; go to CMD.
  - busy=1 and req=1 take effect the next cycle.
  - On start with len==0: go to FIN with no bus activity.
- CMD:
  - req=1, vld=1, addr=base_addr+4*idx (mod 2^32).
  - Stay while rdy=0.
  - On vld&rdy: next cycle vld=0, go to RSP.
  - vld is high for exactly one cycle in which rdy is sampled high. Exactly one command per word.
- RSP:
  - req=1, arb2weight_biu_rdy=1.
  - On arb2weight_biu_vld: next cycle wbuf_wr_en=1 for one cycle, wbuf_wr_addr=buf_base+idx (mod 2^BUF_AW), wbuf_wr_data=captured data; idx increments.
  - If idx was len-1: go to FIN, with req dropping that same cycle. Otherwise go to CMD.
  - A response arriving in CMD or IDLE is ignored (rdy=0 there).
- FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- req stays continuously high from the first CMD cycle through the last RSP so the arbiter does not release the grant between words.
- start during CMD/RSP/FIN is ignored, with no latching.
- Throughput: minimum 2 cycles per word plus arbiter/bus latency.

Optional Feature:
- Macro: WEIGHT_BIU_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RSP, cleared on entry to RSP.
  - Reaching TIMEOUT_CYC without arb2weight_biu_vld sets err=1, drops req, and goes to FIN, so done still pulses.
  - The remaining words are not written.
- Undefined: no counter; RSP waits indefinitely; err is tied to 0.

Test Plan:
- len=4, base_addr=0x2000_0000, buf_base=0x010, rdy tied 1, responses 0xA0..0xA3 with 2-cycle latency -> addrs 0x2000_0000/04/08/0C, each vld exactly 1 cycle; writes to 0x010..0x013 with 0xA0..0xA3; one done pulse; req high continuously then low with done.
- rdy held 0 for 5 cycles in CMD -> vld stays high with addr stable; exactly one command once rdy=1.
- len=0 start -> done pulse two cycles later; req/vld/wbuf_wr_en never asserted.
- base_addr=0xFFFF_FFF8, len=3, buf_base=2^BUF_AW-1 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; buf addrs 0x3FF, 0x000, 0x001.
- rst_n pulsed low during RSP of word 2 of 8 -> all outputs 0 immediately; no done; next start behaves normally.
- With WEIGHT_BIU_TIMEOUT_EN and TIMEOUT_CYC=16, no response to word 0 -> err=1 at cycle 16 of RSP, req low, done pulses, no buffer write; next start clears err.

Source files
------------

// File: rtl/weight_biu.sv
// weight_biu: streams a contiguous block of weight words from memory into the weight buffer.
// Optional RSP watchdog enabled by defining WEIGHT_BIU_TIMEOUT_EN.
module weight_biu #(
  parameter int LEN_W       = 12,
  parameter int BUF_AW      = 10,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [BUF_AW-1:0] buf_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              weight_biu2arb_req,
  output logic [31:0]       weight_biu2arb_addr,
  output logic              weight_biu2arb_vld,
  input  logic              weight_biu2arb_rdy,
  input  logic [31:0]       arb2weight_biu_data,
  input  logic              arb2weight_biu_vld,
  output logic              arb2weight_biu_rdy,
  output logic              wbuf_wr_en,
  output logic [BUF_AW-1:0] wbuf_wr_addr,
  output logic [31:0]       wbuf_wr_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;
  logic              err_q;
  logic              err_d;
  logic              req_q;
  logic              req_d;
  logic              vld_q;
  logic              vld_d;
  logic [31:0]       addr_q;
  logic [31:0]       addr_d;
  logic              wr_en_q;
  logic              wr_en_d;
  logic [BUF_AW-1:0] wr_addr_q;
  logic [BUF_AW-1:0] wr_addr_d;
  logic [31:0]       wr_data_q;
  logic [31:0]       wr_data_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_d;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  idx_d;
  logic [BUF_AW-1:0] bptr_q;
  logic [BUF_AW-1:0] bptr_d;
  logic              last;
  logic              tmo;

`ifdef WEIGHT_BIU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // counter reads 0 on the first RSP cycle; cleared whenever not in RSP
  always_comb begin
    cnt_d = '0;
    if (state_q == S_RSP) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tmo = (state_q == S_RSP) &&
               (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic tmo_unused;

  assign tmo        = 1'b0;
  assign tmo_unused = (TIMEOUT_CYC != 0);
`endif

  assign last = (idx_q == len_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    req_d     = req_q;
    vld_d     = vld_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    len_d     = len_q;
    idx_d     = idx_q;
    bptr_d    = bptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          err_d  = 1'b0;
          if (len != '0) begin
            len_d   = len;
            idx_d   = '0;
            bptr_d  = buf_base;
            addr_d  = base_addr;
            req_d   = 1'b1;
            vld_d   = 1'b1;
            state_d = S_CMD;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_CMD: begin
        if (weight_biu2arb_rdy) begin
          vld_d   = 1'b0;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (arb2weight_biu_vld) begin
          wr_en_d   = 1'b1;
          wr_addr_d = bptr_q;
          wr_data_d = arb2weight_biu_data;
          bptr_d    = bptr_q + 1'b1;
          idx_d     = idx_q + 1'b1;
          if (last) begin
            req_d   = 1'b0;
            state_d = S_FIN;
          end else begin
            addr_d  = addr_q + 32'd4;
            vld_d   = 1'b1;
            state_d = S_CMD;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      bptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      req_q     <= req_d;
      vld_q     <= vld_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      bptr_q    <= bptr_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;
  assign weight_biu2arb_req  = req_q;
  assign weight_biu2arb_addr = addr_q;
  assign weight_biu2arb_vld  = vld_q;
  assign arb2weight_biu_rdy  = (state_q == S_RSP);
  assign wbuf_wr_en          = wr_en_q;
  assign wbuf_wr_addr        = wr_addr_q;
  assign wbuf_wr_data        = wr_data_q;

endmodule
